// File: rtl/ras_controller.sv
// Return-address-stack front-end driver: decodes JAL/JALR link hints into RAS
// push/pop operations, sequences checkpoint/restore, and presents pop results as predictions.
module ras_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            ckpt_valid,
    output logic            ckpt_ready,
    input  logic            mispredict,
    output logic [XLEN-1:0] ras_address_in,
    output logic            ras_valid_in,
    output logic            ras_op,
    output logic            ras_checkpoint,
    output logic            ras_restore_checkpoint,
    input  logic [XLEN-1:0] ras_address_out,
    input  logic            ras_valid_out,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_target,
    output logic            pred_hit
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_POP_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_PUSH     = 2'd1,
        ACT_POP      = 2'd2,
        ACT_POP_PUSH = 2'd3
    } action_t;

    state_t          state_q, state_d;
    logic            push_pending_q, push_pending_d;
    logic [XLEN-1:0] push_addr_q, push_addr_d;
    logic [XLEN-1:0] link_addr_s;
    action_t         action_s;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic action_t decode_action(input logic [31:0] w);
        logic [4:0] rd;
        logic [4:0] rs1;
        action_t    act;
        rd  = w[11:7];
        rs1 = w[19:15];
        act = ACT_NONE;
        if (w[6:0] == 7'b1101111) begin
            act = is_link(rd) ? ACT_PUSH : ACT_NONE;
        end else if ((w[6:0] == 7'b1100111) && (w[14:12] == 3'b000)) begin
            case ({is_link(rd), is_link(rs1)})
                2'b00:   act = ACT_NONE;
                2'b01:   act = ACT_POP;
                2'b10:   act = ACT_PUSH;
                2'b11:   act = (rd == rs1) ? ACT_PUSH : ACT_POP_PUSH;
                default: act = ACT_NONE;
            endcase
        end else begin
            act = ACT_NONE;
        end
        return act;
    endfunction

    assign action_s    = decode_action(instr);
    assign link_addr_s = pc + XLEN'(4);

    // State and latched push request; async reset drops any pending push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            push_pending_q <= 1'b0;
            push_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            push_pending_q <= push_pending_d;
            push_addr_q    <= push_addr_d;
        end
    end

    // Next state and outputs; outputs are forced low while reset is held.
    always_comb begin
        state_d                = state_q;
        push_pending_d         = push_pending_q;
        push_addr_d            = push_addr_q;
        instr_ready            = 1'b0;
        ckpt_ready             = 1'b0;
        ras_address_in         = '0;
        ras_valid_in           = 1'b0;
        ras_op                 = 1'b0;
        ras_checkpoint         = 1'b0;
        ras_restore_checkpoint = 1'b0;
        pred_valid             = 1'b0;
        pred_target            = '0;
        pred_hit               = 1'b0;

        if (reset) begin
            state_d        = ST_IDLE;
            push_pending_d = 1'b0;
        end else if (mispredict) begin
            ras_restore_checkpoint = 1'b1;
            state_d                = ST_IDLE;
            push_pending_d         = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ckpt_ready  = 1'b1;
                    instr_ready = !ckpt_valid;
                    // The checkpoint is older than a concurrent instruction, so it takes the cycle.
                    if (ckpt_valid) begin
                        ras_checkpoint = 1'b1;
                    end else if (instr_valid) begin
                        case (action_s)
                            ACT_PUSH: begin
                                ras_valid_in   = 1'b1;
                                ras_op         = 1'b0;
                                ras_address_in = link_addr_s;
                            end
                            ACT_POP, ACT_POP_PUSH: begin
                                ras_valid_in   = 1'b1;
                                ras_op         = 1'b1;
                                push_addr_d    = link_addr_s;
                                push_pending_d = (action_s == ACT_POP_PUSH);
                                state_d        = ST_POP_WAIT;
                            end
                            default: begin
                                ras_valid_in = 1'b0;
                            end
                        endcase
                    end else begin
                        ras_valid_in = 1'b0;
                    end
                end
                ST_POP_WAIT: begin
                    pred_valid     = 1'b1;
                    pred_target    = ras_address_out;
                    pred_hit       = ras_valid_out;
                    if (push_pending_q) begin
                        ras_valid_in   = 1'b1;
                        ras_op         = 1'b0;
                        ras_address_in = push_addr_q;
                    end else begin
                        ras_valid_in = 1'b0;
                    end
                    push_pending_d = 1'b0;
                    state_d        = ST_IDLE;
                end
                default: begin
                    state_d        = ST_IDLE;
                    push_pending_d = 1'b0;
                end
            endcase
        end
    end

endmodule
